// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - two-stage pipelined bitwise logic unit with accumulate, flags and beat counter
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             par,
    output logic [CNT_W-1:0] beat_cnt
);

    typedef enum logic [2:0] {
        OP_NOT  = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_XOR  = 3'd3,
        OP_NOR  = 3'd4,
        OP_NAND = 3'd5,
        OP_XNOR = 3'd6,
        OP_PASS = 3'd7
    } op_t;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] operand_z;
    logic [WIDTH-1:0] result;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_y;
    logic             s1_zero;
    logic             s1_par;
    logic             accept;
    logic             s2_load;
    logic             deliver;

    assign in_ready = !s1_valid || !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign deliver  = out_valid && out_ready;

    // Chained beats read the accumulator; a clear seeds the chain from b instead.
    assign operand_z = (acc_en && !acc_clr) ? acc : b;

    always_comb begin
        result = '0;
        case (op_t'(op))
            OP_NOT:  result = ~a;
            OP_AND:  result = a & operand_z;
            OP_OR:   result = a | operand_z;
            OP_XOR:  result = a ^ operand_z;
            OP_NOR:  result = ~(a | operand_z);
            OP_NAND: result = ~(a & operand_z);
            OP_XNOR: result = ~(a ^ operand_z);
            OP_PASS: result = a;
            default: result = a;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (accept && acc_en) begin
            acc <= result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_y     <= '0;
            s1_zero  <= 1'b0;
            s1_par   <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_y     <= result;
            s1_zero  <= (result == '0);
            s1_par   <= ^result;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Output stage holds its data while stalled; only valid drops after a drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            zero      <= 1'b0;
            par       <= 1'b0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            y         <= s1_y;
            zero      <= s1_zero;
            par       <= s1_par;
        end else if (deliver) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (deliver) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

endmodule
